simplecpu_wb_loader: RTL and testbench

Wishbone-slave program loader that sits directly upstream of the SimpleCPU core in the user project area. The management SoC writes a 16-byte program image and control bits over Wishbone. The block then holds the CPU in reset, streams the image into the CPU's 16×8 program RAM one byte per cycle via the `load_ram`/`load_addr`/`load_data` strobe interface, and optionally releases the CPU to run. Replaces manual program loading through logic-analyzer bits.

---
 rtl/simplecpu_loader_pkg.sv | 32 +++
 rtl/simplecpu_loader_seq.sv | 82 ++++++++
 rtl/simplecpu_wb_loader.sv | 154 +++++++++++++++
 tb/tb_simplecpu_wb_loader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simplecpu_loader_pkg.sv
// Shared definitions for the SimpleCPU Wishbone program loader: register map,
// control/status bit positions, sequencer state encoding and fixed sizes.
package simplecpu_loader_pkg;

  localparam int RAM_AW     = 4;
  localparam int PRE_CYCLES = 2;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_LEN    = 8'h08;

  localparam int CTRL_START   = 0;
  localparam int CTRL_HOLD    = 1;
  localparam int CTRL_AUTORUN = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_LOAD = 2'd2,
    S_POST = 2'd3
  } seq_state_t;

  // PROG0..PROG3 live at 0x10, 0x14, 0x18, 0x1C
  function automatic logic is_prog_off(input logic [7:0] off);
    return (off[7:4] == 4'h1) && (off[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/simplecpu_loader_seq.sv
// Load sequencer: IDLE -> PRE -> LOAD -> POST, driving registered, glitch-free
// RAM write strobes from the program buffer one byte per cycle.
module simplecpu_loader_seq
  import simplecpu_loader_pkg::*;
#(
  parameter int RAM_DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [RAM_AW-1:0]      len_i,
  input  logic [RAM_DEPTH*8-1:0] prog_i,
  output logic                   busy_o,
  output logic                   finish_o,
  output logic                   load_ram_o,
  output logic [RAM_AW-1:0]      load_addr_o,
  output logic [7:0]             load_data_o,
  output logic                   irq_o
);

  seq_state_t        state_q;
  logic [1:0]        pre_q;
  logic [RAM_AW-1:0] cnt_q;
  logic [RAM_AW-1:0] cnt_nxt;

  assign cnt_nxt  = cnt_q + 1'b1;
  assign busy_o   = (state_q != S_IDLE);
  assign finish_o = (state_q == S_POST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pre_q       <= '0;
      cnt_q       <= '0;
      load_ram_o  <= 1'b0;
      load_addr_o <= '0;
      load_data_o <= '0;
      irq_o       <= 1'b0;
    end else begin
      // strobe outputs fall back to zero unless a byte is presented this cycle
      load_ram_o  <= 1'b0;
      load_addr_o <= '0;
      load_data_o <= '0;
      irq_o       <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_PRE;
            pre_q   <= 2'(PRE_CYCLES - 1);
          end
        end
        S_PRE: begin
          if (pre_q == 2'd0) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            load_ram_o  <= 1'b1;
            load_data_o <= prog_i[7:0];
          end else begin
            pre_q <= pre_q - 1'b1;
          end
        end
        S_LOAD: begin
          // counter stops at LEN, so it never wraps past the last address
          if (cnt_q == len_i) begin
            state_q <= S_POST;
          end else begin
            cnt_q       <= cnt_nxt;
            load_ram_o  <= 1'b1;
            load_addr_o <= cnt_nxt;
            load_data_o <= prog_i[{cnt_nxt, 3'b000} +: 8];
          end
        end
        S_POST: begin
          state_q <= S_IDLE;
          irq_o   <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/simplecpu_wb_loader.sv
// Wishbone-slave program loader for SimpleCPU: register file, program buffer and
// bus decode. Define SIMPLECPU_LOADER_READBACK_EN to make PROG0-3 readable.
module simplecpu_wb_loader
  import simplecpu_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          RAM_DEPTH = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              load_ram,
  output logic [RAM_AW-1:0] load_addr,
  output logic [7:0]        load_data,
  output logic              cpu_reset,
  output logic              irq_o
);

  logic                   ack_q, ack_d;
  logic [31:0]            dat_q, dat_d, rdata;
  logic                   hold_q, hold_d, autorun_q, autorun_d;
  logic                   done_q, done_d, err_q, err_d;
  logic [RAM_AW-1:0]      len_q, len_d;
  logic                   cpu_reset_q, cpu_reset_d;
  logic [RAM_DEPTH*8-1:0] prog_q;
  logic                   req, wr, prog_sel, start_acc;
  logic                   seq_busy, seq_finish;
  logic [7:0]             off;
  logic [1:0]             prog_idx;

  assign off      = wbs_adr_i[7:0];
  assign prog_sel = is_prog_off(off);
  assign prog_idx = off[3:2];
  assign req      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign ack_d    = req & ~ack_q;
  // writes commit at the end of the ack cycle while the master still holds the bus
  assign wr       = req & ack_q & wbs_we_i;

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: begin
        rdata[CTRL_HOLD]    = hold_q;
        rdata[CTRL_AUTORUN] = autorun_q;
      end
      OFF_STATUS: begin
        rdata[STAT_BUSY] = seq_busy;
        rdata[STAT_DONE] = done_q;
        rdata[STAT_ERR]  = err_q;
      end
      OFF_LEN: rdata[RAM_AW-1:0] = len_q;
      default: begin
`ifdef SIMPLECPU_LOADER_READBACK_EN
        if (prog_sel) rdata = prog_q[{prog_idx, 5'b00000} +: 32];
`endif
      end
    endcase
  end

  assign dat_d = ack_d ? rdata : '0;

  always_comb begin
    hold_d    = hold_q;
    autorun_d = autorun_q;
    len_d     = len_q;
    done_d    = done_q;
    err_d     = err_q;
    start_acc = 1'b0;
    if (seq_finish) begin
      done_d = 1'b1;
      if (autorun_q) hold_d = 1'b0;
    end
    // a CTRL write in the same cycle overrides the autorun release
    if (wr) begin
      if (off == OFF_CTRL) begin
        if (wbs_sel_i[0]) begin
          hold_d    = wbs_dat_i[CTRL_HOLD];
          autorun_d = wbs_dat_i[CTRL_AUTORUN];
          if (wbs_dat_i[CTRL_START]) begin
            if (seq_busy) begin
              err_d = 1'b1;
            end else begin
              start_acc = 1'b1;
              done_d    = 1'b0;
              err_d     = 1'b0;
            end
          end
        end
      end else if (off == OFF_LEN) begin
        if (seq_busy) err_d = 1'b1;
        else if (wbs_sel_i[0]) len_d = wbs_dat_i[RAM_AW-1:0];
      end else if (prog_sel && seq_busy) begin
        err_d = 1'b1;
      end
    end
    cpu_reset_d = hold_d | start_acc | (seq_busy & ~seq_finish);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      hold_q      <= 1'b1;
      autorun_q   <= 1'b0;
      len_q       <= '1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_reset_q <= 1'b1;
      prog_q      <= '0;
    end else begin
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      hold_q      <= hold_d;
      autorun_q   <= autorun_d;
      len_q       <= len_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_reset_q <= cpu_reset_d;
      if (wr && prog_sel && !seq_busy) begin
        for (int k = 0; k < 4; k++) begin
          if (wbs_sel_i[k]) prog_q[{prog_idx, k[1:0], 3'b000} +: 8] <= wbs_dat_i[8*k +: 8];
        end
      end
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign cpu_reset = cpu_reset_q;

  simplecpu_loader_seq #(
    .RAM_DEPTH (RAM_DEPTH)
  ) u_seq (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .start_i     (start_acc),
    .len_i       (len_q),
    .prog_i      (prog_q),
    .busy_o      (seq_busy),
    .finish_o    (seq_finish),
    .load_ram_o  (load_ram),
    .load_addr_o (load_addr),
    .load_data_o (load_data),
    .irq_o       (irq_o)
  );

endmodule

// File: tb/tb_simplecpu_wb_loader.sv
// Self-checking bench for simplecpu_wb_loader: scoreboard of expected RAM writes
// plus per-scenario register and timing checks.
module tb_simplecpu_wb_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        load_ram;
  logic [3:0]  load_addr;
  logic [7:0]  load_data;
  logic        cpu_reset, irq_o;

  always #5 clk = ~clk;

  simplecpu_wb_loader dut (
    .wb_clk_i (clk),       .wb_rst_i (wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .load_ram (load_ram),  .load_addr(load_addr), .load_data(load_data),
    .cpu_reset(cpu_reset), .irq_o    (irq_o)
  );

  int n_checks = 0, n_fail = 0;
  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic [11:0] exp_q[$];
  logic [7:0]  mem_m[16];
  logic [3:0]  len_m;
  int irq_cnt = 0, irq_cyc = 0, load_seen = 0, first_load_cyc = 0, last_load_cyc = 0;
  logic prev_load = 1'b0;

  // Monitor: pops the scoreboard on every RAM write strobe
  always @(negedge clk) begin
    logic [11:0] e;
    if (wb_rst_i) begin
      prev_load = 1'b0;
    end else begin
      n_checks++;
      if (load_ram === 1'b1) begin
        if (!prev_load) first_load_cyc = cyc_cnt;
        last_load_cyc = cyc_cnt;
        load_seen++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL load_unexpected: got addr=%0d data=%02h, required no write", load_addr, load_data);
        end else begin
          e = exp_q.pop_front();
          if ({load_addr, load_data} !== e) begin
            n_fail++;
            $display("FAIL load_byte: got addr=%0d data=%02h, required addr=%0d data=%02h",
                     load_addr, load_data, e[11:8], e[7:0]);
          end
        end
      end else if (load_addr !== 4'd0 || load_data !== 8'd0 || load_ram !== 1'b0) begin
        n_fail++;
        $display("FAIL load_idle: got ram=%b addr=%0d data=%02h, required 0/0/00", load_ram, load_addr, load_data);
      end
      prev_load = (load_ram === 1'b1);
      if (irq_o === 1'b1) begin
        irq_cnt++;
        irq_cyc = cyc_cnt;
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = 8'h00;
    len_m = 4'hF;
    exp_q.delete();
  endtask

  task automatic push_expected();
    for (int i = 0; i <= int'(len_m); i++) exp_q.push_back({4'(i), mem_m[i]});
  endtask

  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat, output int ack_cyc,
                           output logic ack_after);
    @(negedge clk);
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
    ack_cyc = -1; rdat = '0; ack_after = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o === 1'b1) begin
        ack_cyc = cyc_cnt;
        rdat = wbs_dat_o;
        break;
      end
    end
    if (ack_cyc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL wb_ack_timeout: got no ack at addr %08h, required ack within 8 cycles", adr);
    end else begin
      @(posedge clk); #1;
      ack_after = wbs_ack_o;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel, output int t);
    logic [31:0] rd;
    logic a2;
    wb_access(BASE | 32'(off), 1'b1, d, sel, rd, t, a2);
  endtask

  task automatic wb_read(input logic [7:0] off, output logic [31:0] d);
    int t;
    logic a2;
    wb_access(BASE | 32'(off), 1'b0, '0, 4'hF, d, t, a2);
  endtask

  task automatic write_prog(input int n, input logic [31:0] d, input logic [3:0] sel);
    int t;
    wb_write(8'h10 + 8'(4 * n), d, sel, t);
    for (int k = 0; k < 4; k++) if (sel[k]) mem_m[4 * n + k] = d[8 * k +: 8];
  endtask

  task automatic wait_irq(input int prev, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (irq_cnt != prev) begin ok = 1; break; end
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL irq_timeout: got no irq_o, required one within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    wb_rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({cpu_reset, load_ram, irq_o, wbs_ack_o} !== 4'b1000 || wbs_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cpu_reset=%b load_ram=%b irq=%b ack=%b dat=%08h, required 1/0/0/0/0",
               cpu_reset, load_ram, irq_o, wbs_ack_o, wbs_dat_o);
    end
    wb_rst_i = 1'b0;
    model_reset();
    wb_read(8'h04, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %08h, required 00000000", d); end
    wb_read(8'h08, d);
    n_checks++;
    if (d !== 32'hF) begin n_fail++; $display("FAIL reset_len: got %08h, required 0000000f", d); end
    wb_read(8'h00, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL reset_ctrl: got %08h, required 00000002", d); end
  endtask

  task automatic test_full_load();
    int t, prev;
    logic [31:0] d;
    write_prog(0, 32'h0403_0201, 4'hF);
    write_prog(1, 32'h0807_0605, 4'hF);
    write_prog(2, 32'h0C0B_0A09, 4'hF);
    write_prog(3, 32'h100F_0E0D, 4'hF);
    push_expected();
    prev = irq_cnt;
    wb_write(8'h00, 32'h5, 4'hF, t);
    n_checks++;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL full_cpu_reset_busy: got %b, required 1", cpu_reset); end
    wait_irq(prev, 40);
    n_checks++;
    if (irq_cyc != t + 20) begin n_fail++; $display("FAIL full_irq_time: got cycle %0d, required %0d", irq_cyc, t + 20); end
    n_checks++;
    if (first_load_cyc != t + 3 || last_load_cyc != t + 18) begin
      n_fail++;
      $display("FAIL full_load_window: got %0d..%0d, required %0d..%0d", first_load_cyc, last_load_cyc, t + 3, t + 18);
    end
    n_checks++;
    if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL full_autorun_release: got cpu_reset=%b, required 0", cpu_reset); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL full_missing_bytes: got %0d left, required 0", exp_q.size()); end
    @(negedge clk); #1;
    n_checks++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL full_irq_pulse: got irq=%b a cycle later, required 0", irq_o); end
    wb_read(8'h04, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL full_status: got %08h, required 00000002", d); end
  endtask

  task automatic test_partial();
    int t, prev;
    logic [31:0] d;
    do_reset();
    wb_write(8'h08, 32'h3, 4'hF, t);
    len_m = 4'd3;
    write_prog(0, 32'hAABB_CCDD, 4'b0101);
    push_expected();
    prev = irq_cnt;
    wb_write(8'h00, 32'h3, 4'hF, t);
    wait_irq(prev, 30);
    n_checks++;
    if (irq_cyc != t + 8 || last_load_cyc != t + 6) begin
      n_fail++;
      $display("FAIL partial_timing: got irq %0d last %0d, required %0d %0d", irq_cyc, last_load_cyc, t + 8, t + 6);
    end
    n_checks++;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL partial_hold: got cpu_reset=%b, required 1", cpu_reset); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL partial_missing: got %0d left, required 0", exp_q.size()); end
    wb_read(8'h04, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL partial_status: got %08h, required 00000002", d); end
  endtask

  task automatic test_len0();
    int t, prev;
    wb_write(8'h08, 32'h0, 4'hF, t);
    len_m = 4'd0;
    push_expected();
    prev = irq_cnt;
    wb_write(8'h00, 32'h3, 4'hF, t);
    wait_irq(prev, 20);
    n_checks++;
    if (irq_cyc != t + 5 || first_load_cyc != t + 3 || last_load_cyc != t + 3) begin
      n_fail++;
      $display("FAIL len0_timing: got irq %0d load %0d..%0d, required %0d %0d..%0d",
               irq_cyc, first_load_cyc, last_load_cyc, t + 5, t + 3, t + 3);
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL len0_missing: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_collision();
    int t, t2, prev;
    logic [31:0] d;
    wb_write(8'h08, 32'hF, 4'hF, t);
    len_m = 4'hF;
    push_expected();
    prev = irq_cnt;
    wb_write(8'h00, 32'h3, 4'hF, t);
    repeat (2) @(posedge clk);
    wb_write(8'h00, 32'h3, 4'hF, t2);
    wb_write(8'h1C, 32'hFFFF_FFFF, 4'hF, t2);
    wait_irq(prev, 40);
    n_checks++;
    if (irq_cyc != t + 20) begin n_fail++; $display("FAIL collision_irq_time: got %0d, required %0d", irq_cyc, t + 20); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL collision_missing: got %0d left, required 0", exp_q.size()); end
    wb_read(8'h04, d);
    n_checks++;
    if (d !== 32'h6) begin n_fail++; $display("FAIL collision_status: got %08h, required 00000006", d); end
    repeat (25) @(negedge clk);
    n_checks++;
    if (irq_cnt != prev + 1) begin n_fail++; $display("FAIL collision_extra_irq: got %0d irqs, required %0d", irq_cnt - prev, 1); end
  endtask

  task automatic test_reset_midload();
    int t, prev, base;
    logic [31:0] d;
    push_expected();
    prev = irq_cnt;
    base = load_seen;
    wb_write(8'h00, 32'h1, 4'hF, t);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (load_seen - base == 5) break;
    end
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({load_ram, cpu_reset, irq_o, wbs_ack_o} !== 4'b0100 || load_addr !== 4'd0 || load_data !== 8'd0) begin
      n_fail++;
      $display("FAIL midload_reset: got ram=%b rst=%b irq=%b ack=%b addr=%0d data=%02h, required 0/1/0/0/0/00",
               load_ram, cpu_reset, irq_o, wbs_ack_o, load_addr, load_data);
    end
    wb_rst_i = 1'b0;
    model_reset();
    repeat (25) @(negedge clk);
    n_checks++;
    if (irq_cnt != prev) begin n_fail++; $display("FAIL midload_irq: got %0d irqs, required 0", irq_cnt - prev); end
    wb_read(8'h04, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL midload_status: got %08h, required 00000000", d); end
    wb_read(8'h00, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL midload_ctrl: got %08h, required 00000002", d); end
  endtask

  task automatic test_readback();
    logic [31:0] d, exp_rb;
    int t;
    logic a2;
    write_prog(2, 32'h1234_5678, 4'hF);
`ifdef SIMPLECPU_LOADER_READBACK_EN
    exp_rb = {mem_m[11], mem_m[10], mem_m[9], mem_m[8]};
`else
    exp_rb = 32'h0;
`endif
    wb_read(8'h18, d);
    n_checks++;
    if (d !== exp_rb) begin n_fail++; $display("FAIL readback_prog2: got %08h, required %08h", d, exp_rb); end
    wb_write(8'h40, 32'hFFFF_FFFF, 4'hF, t);
    wb_access(BASE | 32'h40, 1'b0, '0, 4'hF, d, t, a2);
    n_checks++;
    if (t < 0 || d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got ack_cyc=%0d dat=%08h, required ack and 0", t, d); end
    n_checks++;
    if (a2 !== 1'b0) begin n_fail++; $display("FAIL ack_single: got ack=%b in following cycle, required 0", a2); end
    wb_read(8'h08, d);
    n_checks++;
    if (d !== 32'hF) begin n_fail++; $display("FAIL unmapped_write_len: got %08h, required 0000000f", d); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_load();
    test_partial();
    test_len0();
    test_collision();
    test_reset_midload();
    test_readback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
